// File: rtl/ecall_io_unit_if.sv
// Core-side ecall handshake: request decodes and a0 value in, stall and read-int result back.
interface ecall_io_unit_if;
    logic        eRead;
    logic        eWrite;
    logic        eBreak;
    logic [31:0] wdata;
    logic        hold;
    logic [31:0] rdata;
    logic        rdata_we;

    modport master (output eRead, eWrite, eBreak, wdata, input hold, rdata, rdata_we);
    modport slave  (input eRead, eWrite, eBreak, wdata, output hold, rdata, rdata_we);
endinterface

// File: rtl/ecall_io_unit.sv
// Services print-int / read-int / ebreak ecalls against the board switches, confirm button and 7-seg.
// Read-int and ebreak stall the core until the user releases and then presses the confirm button.
module ecall_io_unit #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int SW_WIDTH        = 16,
    parameter int SIGN_EXT        = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    ecall_io_unit_if.slave      core,
    input  logic [SW_WIDTH-1:0] sw,
    input  logic                btn_confirm,
    output logic [31:0]         disp_data,
    output logic                disp_valid,
    output logic                waiting
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_REL, WAIT_PRESS, DONE} state_t;

    state_t              state_reg, state_next;
    logic [SW_WIDTH-1:0] sw_meta_reg, sw_sync_reg;
    logic                btn_meta_reg, btn_sync_reg, btn_deb_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                is_read_reg;
    logic [31:0]         rdata_reg, disp_data_reg;
    logic                disp_valid_reg;
    logic [31:0]         sw_ext;
    logic                hold_fsm;

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            btn_meta_reg <= 1'b0;
            btn_sync_reg <= 1'b0;
        end else begin
            sw_meta_reg  <= sw;
            sw_sync_reg  <= sw_meta_reg;
            btn_meta_reg <= btn_confirm;
            btn_sync_reg <= btn_meta_reg;
        end
    end

    // Debounced state follows the synced button only after it has differed for DEBOUNCE_CYCLES edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            btn_deb_reg <= 1'b0;
        end else if (btn_sync_reg == btn_deb_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg >= CNT_LAST) begin
            btn_deb_reg <= btn_sync_reg;
            cnt_reg     <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign sw_ext = (SIGN_EXT != 0) ? 32'($signed(sw_sync_reg)) : 32'(sw_sync_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_fsm   = 1'b0;
        waiting    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // eBreak wins over eRead; both stall in this very cycle so the PC never slips
                if (core.eBreak || core.eRead) begin
                    state_next = WAIT_REL;
                    hold_fsm   = 1'b1;
                end
            end
            WAIT_REL: begin
                hold_fsm = 1'b1;
                waiting  = 1'b1;
                if (!btn_deb_reg) state_next = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                hold_fsm = 1'b1;
                waiting  = 1'b1;
                if (btn_deb_reg) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gated by rst_n so a still-asserted eRead cannot stall the core while reset is held
    assign core.hold     = rst_n & hold_fsm;
    assign core.rdata_we = (state_reg == DONE) & is_read_reg;
    assign core.rdata    = rdata_reg;
    assign disp_data     = disp_data_reg;
    assign disp_valid    = disp_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_read_reg    <= 1'b0;
            rdata_reg      <= '0;
            disp_data_reg  <= '0;
            disp_valid_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE) begin
                if (core.eBreak || core.eRead) begin
                    is_read_reg <= ~core.eBreak;
                end else if (core.eWrite) begin
                    disp_data_reg  <= core.wdata;
                    disp_valid_reg <= 1'b1;
                end
            end
            if ((state_reg == WAIT_PRESS) && btn_deb_reg && is_read_reg) begin
                rdata_reg <= sw_ext;
            end
        end
    end
endmodule
